// File: rtl/ws281x_pattern_gen.sv
// Pixel-stream source for a WS281x LED chain: whole frames of hue-wheel, solid or
// blank pixels with brightness scaling, followed by a fixed inter-frame gap.
module ws281x_pattern_gen #(
    parameter int unsigned NumLeds    = 8,
    parameter int unsigned StepCycles = 2_500_000,
    parameter int unsigned HueSpread  = 24,
    parameter int unsigned GapCycles  = 4_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic [1:0]  mode_i,
    input  logic [23:0] colour_i,
    input  logic [7:0]  bright_i,
    output logic [23:0] data_o,
    output logic        data_valid_o,
    output logic        data_last_o,
    input  logic        data_ack_i,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam int unsigned IdxW  = (NumLeds > 1) ? $clog2(NumLeds) : 1;
    localparam int unsigned StepW = (StepCycles > 1) ? $clog2(StepCycles) : 1;
    localparam int unsigned GapW  = (GapCycles > 1) ? $clog2(GapCycles) : 1;
    localparam int unsigned HueW  = 8;

    localparam logic [HueW-1:0] HueMax      = 8'd191;
    localparam logic [1:0]      ModeOff     = 2'd0;
    localparam logic [1:0]      ModeSolid   = 2'd1;
    localparam logic [1:0]      ModeRainbow = 2'd2;
    localparam logic [1:0]      ModeWheel   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [StepW-1:0]  step_cnt_q;
    logic [HueW-1:0]   base_hue_q;
    logic [1:0]        frame_mode_q;
    logic [23:0]       frame_colour_q;
    logic [7:0]        frame_bright_q;
    logic [IdxW-1:0]   pix_idx_q, pix_idx_d;
    logic [HueW-1:0]   pix_hue_q, pix_hue_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              snap;
    logic              send;
    logic              is_last;
    logic [23:0]       level;

    // Six-segment wheel: one channel ramps while the other two sit at full/zero.
    function automatic logic [23:0] hue_to_rgb(input logic [HueW-1:0] h);
        logic [7:0] up;
        logic [7:0] dn;
        up = {h[4:0], 3'b000};
        dn = 8'd248 - up;
        case (h[7:5])
            3'd0:    hue_to_rgb = {8'd248, up,     8'd0};
            3'd1:    hue_to_rgb = {dn,     8'd248, 8'd0};
            3'd2:    hue_to_rgb = {8'd0,   8'd248, up};
            3'd3:    hue_to_rgb = {8'd0,   dn,     8'd248};
            3'd4:    hue_to_rgb = {up,     8'd0,   8'd248};
            3'd5:    hue_to_rgb = {8'd248, 8'd0,   dn};
            default: hue_to_rgb = 24'd0;
        endcase
    endfunction

    function automatic logic [7:0] scale(input logic [7:0] lvl, input logic [7:0] br);
        logic [16:0] prod;
        prod  = 17'(lvl) * (17'(br) + 17'd1);
        scale = 8'(prod >> 8);
    endfunction

    function automatic logic [HueW-1:0] hue_add(input logic [HueW-1:0] h);
        logic [HueW:0] sum;
        sum = {1'b0, h} + 9'(HueSpread);
        hue_add = (sum > {1'b0, HueMax}) ? 8'(sum - 9'd192) : 8'(sum);
    endfunction

    // Base-hue step timer; frozen while disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step_cnt_q <= '0;
            base_hue_q <= '0;
        end else if (enable_i) begin
            if (step_cnt_q == StepW'(StepCycles - 1)) begin
                step_cnt_q <= '0;
                base_hue_q <= (base_hue_q == HueMax) ? '0 : base_hue_q + 8'd1;
            end else begin
                step_cnt_q <= step_cnt_q + StepW'(1);
            end
        end
    end

    assign send    = (state_q == S_SEND);
    assign is_last = (pix_idx_q == IdxW'(NumLeds - 1));

    always_comb begin
        state_d      = state_q;
        pix_idx_d    = pix_idx_q;
        pix_hue_d    = pix_hue_q;
        gap_cnt_d    = gap_cnt_q;
        frame_done_d = 1'b0;
        snap         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    snap      = 1'b1;
                    pix_idx_d = '0;
                    pix_hue_d = base_hue_q;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (data_ack_i) begin
                    pix_idx_d = pix_idx_q + IdxW'(1);
                    if (frame_mode_q == ModeWheel) begin
                        pix_hue_d = hue_add(pix_hue_q);
                    end
                    if (is_last) begin
                        frame_done_d = 1'b1;
                        gap_cnt_d    = '0;
                        state_d      = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GapW'(GapCycles - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            pix_idx_q      <= '0;
            pix_hue_q      <= '0;
            gap_cnt_q      <= '0;
            frame_done_q   <= 1'b0;
            frame_mode_q   <= ModeOff;
            frame_colour_q <= '0;
            frame_bright_q <= '0;
        end else begin
            state_q      <= state_d;
            pix_idx_q    <= pix_idx_d;
            pix_hue_q    <= pix_hue_d;
            gap_cnt_q    <= gap_cnt_d;
            frame_done_q <= frame_done_d;
            if (snap) begin
                frame_mode_q   <= mode_i;
                frame_colour_q <= colour_i;
                frame_bright_q <= bright_i;
            end
        end
    end

    // Unscaled pixel level from the frame snapshot.
    always_comb begin
        level = '0;
        case (frame_mode_q)
            ModeOff:     level = '0;
            ModeSolid:   level = frame_colour_q;
            ModeRainbow: level = hue_to_rgb(pix_hue_q);
            ModeWheel:   level = hue_to_rgb(pix_hue_q);
            default:     level = '0;
        endcase
    end

    assign data_o       = send ? {scale(level[23:16], frame_bright_q),
                                  scale(level[15:8],  frame_bright_q),
                                  scale(level[7:0],   frame_bright_q)} : 24'd0;
    assign data_valid_o = send;
    assign data_last_o  = send && is_last;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_ws281x_pattern_gen.sv
// Scoreboard bench for ws281x_pattern_gen: stimulus queues expected pixels,
// a negedge monitor pops and compares on every valid/ack handshake.
module tb_ws281x_pattern_gen;

    localparam int unsigned NumLeds    = 4;
    localparam int unsigned StepCycles = 10;
    localparam int unsigned HueSpread  = 48;
    localparam int unsigned GapCycles  = 5;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic [1:0]  mode_i;
    logic [23:0] colour_i;
    logic [7:0]  bright_i;
    logic [23:0] data_o;
    logic        data_valid_o;
    logic        data_last_o;
    logic        data_ack_i;
    logic        busy_o;
    logic        frame_done_o;

    typedef struct packed {
        logic [23:0] rgb;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_hs     = 0;
    logic ack_en   = 1'b0;
    logic spurious = 1'b0;

    ws281x_pattern_gen #(
        .NumLeds   (NumLeds),
        .StepCycles(StepCycles),
        .HueSpread (HueSpread),
        .GapCycles (GapCycles)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .mode_i      (mode_i),
        .colour_i    (colour_i),
        .bright_i    (bright_i),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .data_last_o (data_last_o),
        .data_ack_i  (data_ack_i),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [23:0] p0, input logic [23:0] p1,
                              input logic [23:0] p2, input logic [23:0] p3);
        sb.push_back({p0, 1'b0});
        sb.push_back({p1, 1'b0});
        sb.push_back({p2, 1'b0});
        sb.push_back({p3, 1'b1});
    endtask

    task automatic wait_hs(input int target, input int budget);
        int cyc = 0;
        while (n_hs < target && cyc < budget) begin
            @(posedge clk_i);
            cyc++;
        end
        #2;
        if (n_hs < target) begin
            n_checks++;
            n_errors++;
            $display("FAIL hs_timeout: got %0d handshakes, expected %0d", n_hs, target);
        end
    endtask

    task automatic wait_idle(input int budget);
        int cyc = 0;
        do begin
            @(posedge clk_i);
            #2;
            cyc++;
        end while (busy_o && cyc < budget);
        check("idle_reached", 32'(busy_o), 32'd0);
    endtask

    task automatic run_enabled(input int cycles);
        enable_i = 1'b1;
        repeat (cycles) @(posedge clk_i);
        #2;
        enable_i = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"},  32'(data_o),       32'd0);
        check({tag, "_valid"}, 32'(data_valid_o), 32'd0);
        check({tag, "_last"},  32'(data_last_o),  32'd0);
        check({tag, "_busy"},  32'(busy_o),       32'd0);
        check({tag, "_done"},  32'(frame_done_o), 32'd0);
    endtask

    // Driver model: ack 3 cycles after valid; optional stray acks while idle.
    initial begin
        int ack_cnt;
        ack_cnt    = 0;
        data_ack_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (!rst_ni || !data_valid_o) begin
                data_ack_i = spurious;
                ack_cnt    = 0;
            end else if (data_ack_i) begin
                data_ack_i = 1'b0;
                ack_cnt    = 0;
            end else if (ack_en) begin
                ack_cnt++;
                if (ack_cnt >= 3) data_ack_i = 1'b1;
            end
        end
    end

    // Monitor: handshakes against the scoreboard plus stall/gap/done protocol rules.
    initial begin
        logic        prev_valid, prev_ack, prev_last, prev_last_hs, gap_track;
        logic [23:0] prev_data;
        int          gap_len;
        exp_t        e;
        prev_valid = 0; prev_ack = 0; prev_last = 0; prev_last_hs = 0;
        gap_track = 0; prev_data = '0; gap_len = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_valid = 0; prev_ack = 0; prev_last_hs = 0; gap_track = 0;
            end else begin
                check("frame_done", 32'(frame_done_o), 32'(prev_last_hs));
                if (prev_last_hs) begin
                    check("valid_drop", 32'(data_valid_o), 32'd0);
                    gap_track = 1;
                    gap_len   = 0;
                end
                if (prev_valid && !prev_ack) begin
                    check("stall_valid", 32'(data_valid_o), 32'd1);
                    check("stall_data",  32'(data_o),       32'(prev_data));
                    check("stall_last",  32'(data_last_o),  32'(prev_last));
                end
                if (gap_track) begin
                    if (data_valid_o) begin
                        n_checks++;
                        if (gap_len < int'(GapCycles)) begin
                            n_errors++;
                            $display("FAIL gap: got %0d idle cycles, expected at least %0d",
                                     gap_len, GapCycles);
                        end
                        gap_track = 0;
                    end else begin
                        gap_len++;
                    end
                end
                if (data_valid_o && data_ack_i) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_pixel: got 0x%0h, expected no pixel", data_o);
                    end else begin
                        e = sb.pop_front();
                        check("pixel_data", 32'(data_o),      32'(e.rgb));
                        check("pixel_last", 32'(data_last_o), 32'(e.last));
                    end
                    n_hs++;
                end
                prev_valid   = data_valid_o;
                prev_ack     = data_ack_i;
                prev_data    = data_o;
                prev_last    = data_last_o;
                prev_last_hs = data_valid_o && data_ack_i && data_last_o;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int   base;
        int   cnt;
        logic found;

        // Reset with enable high, SOLID colour, full brightness
        rst_ni   = 1'b0;
        enable_i = 1'b1;
        mode_i   = 2'd1;
        colour_i = 24'h102030;
        bright_i = 8'd255;
        ack_en   = 1'b1;
        repeat (3) @(posedge clk_i);
        #2;
        check_outputs_zero("rst");
        push_frame(24'h102030, 24'h102030, 24'h102030, 24'h102030);
        rst_ni = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!found) begin
                @(posedge clk_i);
                #2;
                found = data_valid_o;
            end
        end
        check("valid_rise", 32'(found), 32'd1);

        // Brightness and colour changes only land on the following frame
        wait_hs(1, 100);
        bright_i = 8'd127;
        push_frame(24'h081018, 24'h081018, 24'h081018, 24'h081018);
        wait_hs(5, 200);
        colour_i = 24'h405060;
        bright_i = 8'd255;
        push_frame(24'h405060, 24'h405060, 24'h405060, 24'h405060);

        // Reset while pixel 2 of the third frame is presented
        wait_hs(10, 200);
        rst_ni = 1'b0;
        #1;
        check_outputs_zero("midrst");
        sb.delete();
        repeat (2) @(posedge clk_i);
        #2;
        push_frame(24'h405060, 24'h405060, 24'h405060, 24'h405060);
        rst_ni = 1'b1;
        base   = n_hs;
        wait_hs(base + 1, 100);
        enable_i = 1'b0;
        wait_idle(200);
        check("sb_empty_a", 32'(sb.size()), 32'd0);

        // WHEEL from base hue 0 at half brightness
        rst_ni   = 1'b0;
        mode_i   = 2'd3;
        bright_i = 8'd127;
        enable_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #2;
        push_frame(24'h7C0000, 24'h3C7C00, 24'h007C7C, 24'h40007C);
        rst_ni = 1'b1;
        base   = n_hs;
        wait_hs(base + 1, 100);
        enable_i = 1'b0;
        wait_idle(200);
        check("sb_empty_b", 32'(sb.size()), 32'd0);

        // Long ack stalls while the hue timer walks to 160, 191, then wraps to 0
        rst_ni   = 1'b0;
        enable_i = 1'b0;
        ack_en   = 1'b0;
        spurious = 1'b1;
        bright_i = 8'd255;
        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #2;
        run_enabled(1600);
        push_frame(24'hF80000, 24'h78F800, 24'h00F8F8, 24'h8000F8);
        ack_en = 1'b1;
        wait_idle(200);
        ack_en = 1'b0;
        run_enabled(310);
        push_frame(24'hF800F8, 24'hF88000, 24'h00F800, 24'h0078F8);
        ack_en = 1'b1;
        wait_idle(200);
        ack_en = 1'b0;
        run_enabled(10);
        push_frame(24'hF80000, 24'h80F800, 24'h00F8F8, 24'h7800F8);
        ack_en = 1'b1;
        wait_idle(200);

        // Drop enable at pixel 1: frame still completes, nothing follows
        enable_i = 1'b1;
        push_frame(24'hF80000, 24'h78F800, 24'h00F8F8, 24'h8000F8);
        base = n_hs;
        wait_hs(base + 1, 100);
        enable_i = 1'b0;
        wait_idle(200);
        cnt = 0;
        repeat (30) begin
            @(posedge clk_i);
            #2;
            if (data_valid_o) cnt++;
        end
        check("no_valid_after_disable", 32'(cnt), 32'd0);
        check("sb_empty_c", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
